inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader_pkg.sv | 20 ++
 rtl/inst_mem_loader_if.sv | 41 ++++
 rtl/inst_mem_loader_ram_bank.sv | 30 +++
 rtl/inst_mem_loader.sv | 172 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding and beat math.
package inst_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // Number of stream beats that make up one instruction word.
    function automatic int calc_beats(input int inst_width, input int s_width);
        return inst_width / s_width;
    endfunction

    // Counter width able to index n items, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Programming stream, read port and status signals of the instruction memory loader.
//
// Handshake: a program beat transfers on every rising clk edge where s_prog_TVALID
// and s_prog_TREADY are both high. The master holds TDATA/TLAST stable while TVALID
// is high and not yet accepted; the slave may drive TREADY independently of TVALID.
interface inst_mem_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int INST_WIDTH = 32,
    parameter int S_WIDTH    = 8
);
    logic [S_WIDTH-1:0]         s_prog_TDATA;
    logic                       s_prog_TVALID;
    logic                       s_prog_TREADY;
    logic                       s_prog_TLAST;

    logic                       rd_en;
    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic [INST_WIDTH-1:0]      rd_data;
    logic                       rd_valid;

    logic                       busy;
    logic                       prog_done;
    logic [ADDR_WIDTH:0]        prog_len;
    logic                       err_partial;
    logic                       err_overflow;
    logic                       rd_parity_err;

    inst_mem_loader_pkg::state_e dbg_state;

    modport master (
        output s_prog_TDATA, s_prog_TVALID, s_prog_TLAST, rd_en, rd_addr,
        input  s_prog_TREADY, rd_data, rd_valid, busy, prog_done, prog_len,
               err_partial, err_overflow, rd_parity_err, dbg_state
    );

    modport slave (
        input  s_prog_TDATA, s_prog_TVALID, s_prog_TLAST, rd_en, rd_addr,
        output s_prog_TREADY, rd_data, rd_valid, busy, prog_done, prog_len,
               err_partial, err_overflow, rd_parity_err, dbg_state
    );
endinterface

// File: rtl/inst_mem_loader_ram_bank.sv
// Simple dual-port RAM: one synchronous write port, one registered read port (read-first).
module inst_ram_bank #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/inst_mem_loader.sv
// Loads a program from a byte stream into instruction RAM and serves single-cycle reads.
// Optional build macro INST_MEM_PARITY_EN stores an even-parity bit per word.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int INST_WIDTH = 32,
    parameter int S_WIDTH    = 8
) (
    input logic              clk,
    input logic              rst_n,
    inst_mem_loader_if.slave bus
);
    localparam int BEATS  = calc_beats(INST_WIDTH, S_WIDTH);
    localparam int BEAT_W = cnt_width(BEATS);
`ifdef INST_MEM_PARITY_EN
    localparam int RAM_W  = INST_WIDTH + 1;
`else
    localparam int RAM_W  = INST_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [BEAT_W-1:0]   BEAT_ONE = BEAT_W'(1);
    localparam logic [BEAT_W-1:0]   BEAT_MAX = BEAT_W'(BEATS - 1);

    state_e                state_q;
    logic                  tready_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  errp_q;
    logic                  erro_q;
    logic [INST_WIDTH-1:0] pack_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  rd_valid_q;

    logic                  accept;
    logic                  last_lane;
    logic                  word_done;
    logic                  overflow_beat;
    logic [ADDR_WIDTH:0]   len_base;
    logic [INST_WIDTH-1:0] assembled;

    logic                  we_d;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [RAM_W-1:0]      wdata_d;
    logic                  re_d;
    logic [RAM_W-1:0]      ram_rdata;

    assign accept    = bus.s_prog_TVALID & tready_q;
    assign last_lane = (beat_q == BEAT_MAX);
    assign word_done = last_lane | bus.s_prog_TLAST;
    // A fresh load always restarts counting from zero, whatever the previous load left.
    assign len_base  = (state_q == ST_IDLE) ? '0 : len_q;
    // len_q's top bit is set only when all DEPTH words are already written.
    assign overflow_beat = (state_q == ST_LOAD) && (beat_q == '0) && len_q[ADDR_WIDTH];

    // Lanes above the current beat are still zero in pack_q, so a short word is zero-padded.
    always_comb begin
        assembled = pack_q;
        assembled[int'(beat_q) * S_WIDTH +: S_WIDTH] = bus.s_prog_TDATA;
    end

    assign we_d    = accept && (state_q != ST_DROP) && !overflow_beat && word_done;
    assign waddr_d = (state_q == ST_IDLE) ? '0 : len_q[ADDR_WIDTH-1:0];
`ifdef INST_MEM_PARITY_EN
    assign wdata_d = {^assembled, assembled};
`else
    assign wdata_d = assembled;
`endif
    assign re_d    = bus.rd_en & ~busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            errp_q     <= 1'b0;
            erro_q     <= 1'b0;
            pack_q     <= '0;
            beat_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            tready_q   <= 1'b1;
            done_q     <= 1'b0;
            rd_valid_q <= re_d;
            if (accept) begin
                case (state_q)
                    ST_IDLE, ST_LOAD: begin
                        if (state_q == ST_IDLE) begin
                            errp_q <= 1'b0;
                            erro_q <= 1'b0;
                        end
                        if (overflow_beat) begin
                            erro_q <= 1'b1;
                            if (bus.s_prog_TLAST) begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_DROP;
                                busy_q  <= 1'b1;
                            end
                        end else if (word_done) begin
                            len_q  <= len_base + LEN_ONE;
                            pack_q <= '0;
                            beat_q <= '0;
                            if (bus.s_prog_TLAST) begin
                                if (!last_lane) begin
                                    errp_q <= 1'b1;
                                end
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            len_q   <= len_base;
                            pack_q  <= assembled;
                            beat_q  <= beat_q + BEAT_ONE;
                            state_q <= ST_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (bus.s_prog_TLAST) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    inst_ram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (RAM_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we_d),
        .waddr_i (waddr_d),
        .wdata_i (wdata_d),
        .re_i    (re_d),
        .raddr_i (bus.rd_addr),
        .rdata_o (ram_rdata)
    );

    assign bus.s_prog_TREADY = tready_q;
    assign bus.busy          = busy_q;
    assign bus.prog_done     = done_q;
    assign bus.prog_len      = len_q;
    assign bus.err_partial   = errp_q;
    assign bus.err_overflow  = erro_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = ram_rdata[INST_WIDTH-1:0];
    assign bus.dbg_state     = state_q;
`ifdef INST_MEM_PARITY_EN
    // Stored word plus its parity bit XOR to zero when intact.
    assign bus.rd_parity_err = rd_valid_q & (^ram_rdata);
`else
    assign bus.rd_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: a 16-word and a 4-word instance share one stimulus stream.
module tb_inst_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tdata = '0;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = '0;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    inst_mem_loader_if #(.ADDR_WIDTH(4), .INST_WIDTH(32), .S_WIDTH(8)) bus_a ();
    inst_mem_loader_if #(.ADDR_WIDTH(2), .INST_WIDTH(32), .S_WIDTH(8)) bus_b ();

    assign bus_a.s_prog_TDATA  = tdata;
    assign bus_a.s_prog_TVALID = tvalid;
    assign bus_a.s_prog_TLAST  = tlast;
    assign bus_a.rd_en         = rd_en;
    assign bus_a.rd_addr       = rd_addr;
    assign bus_b.s_prog_TDATA  = tdata;
    assign bus_b.s_prog_TVALID = tvalid;
    assign bus_b.s_prog_TLAST  = tlast;
    assign bus_b.rd_en         = rd_en;
    assign bus_b.rd_addr       = rd_addr[1:0];

    inst_mem_loader #(.ADDR_WIDTH(4), .INST_WIDTH(32), .S_WIDTH(8)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
    );
    inst_mem_loader #(.ADDR_WIDTH(2), .INST_WIDTH(32), .S_WIDTH(8)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
    );

    // Reference model: program words built from a beat count and an accumulator.
    int          m_mode [2];   // 0 idle, 1 loading, 2 discarding after overflow
    int          m_nb [2];
    logic [31:0] m_acc [2];
    int          m_words [2];
    logic [31:0] m_mem [2][16];
    bit          m_par_bad [2][16];
    bit          m_tready [2], m_busy [2], m_done [2], m_errp [2], m_erro [2];
    bit          m_rdv [2], m_rdpe [2];
    logic [31:0] m_rdd [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_nb[k] = 0; m_acc[k] = '0; m_words[k] = 0;
            m_tready[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_errp[k] = 0;
            m_erro[k] = 0; m_rdv[k] = 0; m_rdpe[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int  depth;
        int  a;
        bit  took;
        depth = (k == 0) ? 16 : 4;
        took  = tvalid && m_tready[k];
        m_tready[k] = 1;
        m_done[k]   = 0;
        m_rdpe[k]   = 0;
        if (rd_en && !m_busy[k]) begin
            a = int'(rd_addr) % depth;
            m_rdv[k]  = 1;
            m_rdd[k]  = m_mem[k][a];
            m_rdpe[k] = m_par_bad[k][a];
        end else begin
            m_rdv[k] = 0;
        end
        if (took) begin
            if (m_mode[k] == 0) begin
                m_mode[k] = 1; m_words[k] = 0; m_errp[k] = 0; m_erro[k] = 0;
                m_nb[k] = 0; m_acc[k] = '0;
            end
            if (m_mode[k] == 2) begin
                if (tlast) begin m_done[k] = 1; m_mode[k] = 0; end
            end else if (m_nb[k] == 0 && m_words[k] == depth) begin
                m_erro[k] = 1;
                if (tlast) begin m_done[k] = 1; m_mode[k] = 0; end
                else m_mode[k] = 2;
            end else begin
                m_acc[k] = m_acc[k] | (32'(tdata) << (8 * m_nb[k]));
                m_nb[k]++;
                if (m_nb[k] == 4 || tlast) begin
                    if (m_nb[k] < 4) m_errp[k] = 1;
                    m_mem[k][m_words[k]] = m_acc[k];
                    m_par_bad[k][m_words[k]] = 0;
                    m_words[k]++;
                    m_nb[k] = 0; m_acc[k] = '0;
                    if (tlast) begin m_done[k] = 1; m_mode[k] = 0; end
                end
            end
        end
        m_busy[k] = (m_mode[k] != 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                m_mem[k][i] = '0;
                m_par_bad[k][i] = 0;
            end
        model_reset();
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic tready, input logic busy, input logic done,
                             input logic [31:0] len, input logic errp, input logic erro,
                             input logic rdv, input logic [31:0] rdd, input logic rdpe);
        chk($sformatf("tready[%0d]", k), 32'(tready), 32'(m_tready[k]));
        chk($sformatf("busy[%0d]", k), 32'(busy), 32'(m_busy[k]));
        chk($sformatf("prog_done[%0d]", k), 32'(done), 32'(m_done[k]));
        chk($sformatf("prog_len[%0d]", k), len, 32'(m_words[k]));
        chk($sformatf("err_partial[%0d]", k), 32'(errp), 32'(m_errp[k]));
        chk($sformatf("err_overflow[%0d]", k), 32'(erro), 32'(m_erro[k]));
        chk($sformatf("rd_valid[%0d]", k), 32'(rdv), 32'(m_rdv[k]));
        chk($sformatf("rd_parity_err[%0d]", k), 32'(rdpe), 32'(m_rdpe[k]));
        if (m_rdv[k]) chk($sformatf("rd_data[%0d]", k), rdd, m_rdd[k]);
    endtask

    always @(negedge clk) begin
        check_dut(0, bus_a.s_prog_TREADY, bus_a.busy, bus_a.prog_done, 32'(bus_a.prog_len),
                  bus_a.err_partial, bus_a.err_overflow, bus_a.rd_valid, bus_a.rd_data,
                  bus_a.rd_parity_err);
        check_dut(1, bus_b.s_prog_TREADY, bus_b.busy, bus_b.prog_done, 32'(bus_b.prog_len),
                  bus_b.err_partial, bus_b.err_overflow, bus_b.rd_valid, bus_b.rd_data,
                  bus_b.rd_parity_err);
        if (bus_a.prog_done) done_cnt_a++;
        if (bus_b.prog_done) done_cnt_b++;
    end

    task automatic send_prog(input logic [7:0] first, input int n, input bit with_last,
                             input int gap, input bit rd_busy);
        for (int i = 0; i < n; i++) begin
            tdata   = first + 8'(i);
            tvalid  = 1'b1;
            tlast   = with_last && (i == n - 1);
            rd_en   = rd_busy && (i >= 2) && (i < n - 1);
            rd_addr = 4'd1;
            @(posedge clk); #1;
            if (rd_busy && i == 3) chk("rd_ignored_busy", 32'(bus_a.rd_valid), 32'd0);
            if (gap != 0 && (i % gap) == gap - 1) begin
                tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0;
                @(posedge clk); #1;
            end
        end
        tvalid = 1'b0; tlast = 1'b0; rd_en = 1'b0;
    endtask

    task automatic read_chk(input logic [3:0] addr, input logic [31:0] exp_a, input logic [31:0] exp_b);
        rd_en = 1'b1; rd_addr = addr;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("rd_valid_a", 32'(bus_a.rd_valid), 32'd1);
        chk("rd_data_a", bus_a.rd_data, exp_a);
        chk("rd_data_b", bus_b.rd_data, exp_b);
        @(posedge clk); #1;
        chk("rd_valid_low_a", 32'(bus_a.rd_valid), 32'd0);
        chk("rd_data_hold_a", bus_a.rd_data, exp_a);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready", 32'(bus_a.s_prog_TREADY), 32'd0);
        chk("reset_busy", 32'(bus_a.busy), 32'd0);
        chk("reset_state", 32'(bus_a.dbg_state), 32'd0);
        chk("reset_prog_len", 32'(bus_a.prog_len), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_reset", 32'(bus_a.s_prog_TREADY), 32'd1);

        // Two full words, reads attempted while busy.
        done_cnt_a = 0;
        send_prog(8'h01, 8, 1'b1, 0, 1'b1);
        settle();
        chk("load1_done_pulses", 32'(done_cnt_a), 32'd1);
        chk("load1_prog_len", 32'(bus_a.prog_len), 32'd2);
        chk("load1_err_partial", 32'(bus_a.err_partial), 32'd0);
        read_chk(4'd0, 32'h04030201, 32'h04030201);
        read_chk(4'd1, 32'h08070605, 32'h08070605);

        // Six beats with idle gaps: second word is zero-padded.
        send_prog(8'h01, 6, 1'b1, 2, 1'b0);
        settle();
        chk("load2_prog_len", 32'(bus_a.prog_len), 32'd2);
        chk("load2_err_partial", 32'(bus_a.err_partial), 32'd1);
        read_chk(4'd1, 32'h00000605, 32'h00000605);

        // Twenty beats: fits the 16-word instance, overflows the 4-word one.
        done_cnt_b = 0;
        send_prog(8'h11, 20, 1'b1, 3, 1'b0);
        settle();
        chk("load3_len_b", 32'(bus_b.prog_len), 32'd4);
        chk("load3_overflow_b", 32'(bus_b.err_overflow), 32'd1);
        chk("load3_done_b", 32'(done_cnt_b), 32'd1);
        chk("load3_idle_b", 32'(bus_b.dbg_state), 32'd0);
        chk("load3_len_a", 32'(bus_a.prog_len), 32'd5);
        chk("load3_overflow_a", 32'(bus_a.err_overflow), 32'd0);
        chk("load3_partial_cleared", 32'(bus_a.err_partial), 32'd0);
        read_chk(4'd4, 32'h24232221, 32'h14131211);
        read_chk(4'd3, 32'h201F1E1D, 32'h201F1E1D);

        // Reset in the middle of a load, then a fresh one-word load.
        send_prog(8'hA1, 3, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(bus_a.busy), 32'd0);
        chk("midreset_prog_len", 32'(bus_a.prog_len), 32'd0);
        chk("midreset_tready", 32'(bus_a.s_prog_TREADY), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_prog(8'hA1, 4, 1'b1, 0, 1'b0);
        settle();
        chk("load4_prog_len", 32'(bus_a.prog_len), 32'd1);
        read_chk(4'd0, 32'hA4A3A2A1, 32'hA4A3A2A1);
        read_chk(4'd1, 32'h18171615, 32'h18171615);

        // Single-beat program taken straight from idle.
        send_prog(8'h5A, 1, 1'b1, 0, 1'b0);
        settle();
        chk("load5_prog_len", 32'(bus_a.prog_len), 32'd1);
        chk("load5_err_partial", 32'(bus_a.err_partial), 32'd1);
        read_chk(4'd0, 32'h0000005A, 32'h0000005A);

`ifdef INST_MEM_PARITY_EN
        dut_a.u_ram.mem_q[0][3] = ~dut_a.u_ram.mem_q[0][3];
        m_mem[0][0][3] = ~m_mem[0][0][3];
        m_par_bad[0][0] = 1;
        rd_en = 1'b1; rd_addr = 4'd0;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("parity_err_a", 32'(bus_a.rd_parity_err), 32'd1);
        chk("parity_data_a", bus_a.rd_data, 32'h00000052);
        chk("parity_ok_b", 32'(bus_b.rd_parity_err), 32'd0);
        settle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
